// File: rtl/rs_232_transmitter_if.sv
// Parallel-side and line-side signals of the RS-232 transmitter.
// The master supplies bytes; the slave (the transmitter) drives the serial line and status.
interface rs_232_transmitter_if;
    logic [7:0] data;
    logic       send;
    logic       rs_232;
    logic       busy;
    logic       done;

    modport master (
        output data,
        output send,
        input  rs_232,
        input  busy,
        input  done
    );

    modport slave (
        input  data,
        input  send,
        output rs_232,
        output busy,
        output done
    );
endinterface

// File: rtl/rs_232_transmitter.sv
// 8N1 serial transmitter: latches a byte on an accepted send strobe and shifts it
// out LSB first between a start and a stop bit, CLKS_PER_BIT cycles per bit.
module rs_232_transmitter #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic                clk,
    input  logic                rst,
    rs_232_transmitter_if.slave bus
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             rs_232_q, rs_232_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            rs_232_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            rs_232_q  <= rs_232_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        done_d    = 1'b0;
        rs_232_d  = 1'b1;
        busy_d    = 1'b0;
        bit_end   = (clk_cnt_q == CNT_LAST);

        if (state_q != IDLE) begin
            clk_cnt_d = bit_end ? '0 : clk_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.send) begin
                    state_d   = START;
                    shift_d   = bus.data;
                    bit_idx_d = '0;
                    clk_cnt_d = '0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so the line and busy flops
        // change on the same edge as the state register.
        case (state_d)
            START:   rs_232_d = 1'b0;
            DATA:    rs_232_d = shift_d[0];
            default: rs_232_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    assign bus.rs_232 = rs_232_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_rs_232_transmitter.sv
// Directed self-checking bench for rs_232_transmitter: table of bytes with
// hand-computed 10-bit frames, plus sequences for busy, back-to-back and reset cases.
module tb_rs_232_transmitter;

    localparam int unsigned C = 16;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    rs_232_transmitter_if bus ();

    rs_232_transmitter #(.CLKS_PER_BIT(C)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // Frame bit i is the line level during serial bit i: {stop, data[7:0], start}.
    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic start_frame(input logic [7:0] d);
        bus.send = 1'b1;
        bus.data = d;
        tick();
        bus.send = 1'b0;
    endtask

    // Called in the first cycle after the accepting edge; returns in the cycle after the done cycle.
    task automatic run_frame(input string nm, input logic [9:0] exp, input bit hold, input int inj);
        int busy_cnt = 0;
        int early_done = 0;
        logic [9:0] got = '0;
        check({nm, " start line"}, int'(bus.rs_232), 0);
        check({nm, " start busy"}, int'(bus.busy), 1);
        for (int c = 0; c < int'(10 * C); c++) begin
            if (bus.busy) busy_cnt++;
            if (bus.done) early_done++;
            if (c % int'(C) == int'(C / 2)) got[c / int'(C)] = bus.rs_232;
            if (hold) begin
                bus.send = 1'b1;
            end else if (c == inj) begin
                bus.send = 1'b1;
                bus.data = 8'hFF;
            end else begin
                bus.send = 1'b0;
            end
            tick();
        end
        check({nm, " frame bits"}, int'(got), int'(exp));
        check({nm, " busy cycles"}, busy_cnt, int'(10 * C));
        check({nm, " done in frame"}, early_done, 0);
        check({nm, " done pulse"}, int'({bus.done, bus.busy, bus.rs_232}), 3'b101);
        tick();
        check({nm, " done width"}, int'(bus.done), 0);
    endtask

    task automatic expect_quiet(input string nm, input int cycles);
        int bad = 0;
        for (int c = 0; c < cycles; c++) begin
            if (bus.busy || bus.done || !bus.rs_232) bad++;
            tick();
        end
        check({nm, " quiet line"}, bad, 0);
    endtask

    initial begin
        vecs[0] = '{8'h55, 10'b1_01010101_0};
        vecs[1] = '{8'h41, 10'b1_01000001_0};
        vecs[2] = '{8'h6C, 10'b1_01101100_0};
        vecs[3] = '{8'h61, 10'b1_01100001_0};
        vecs[4] = '{8'h6E, 10'b1_01101110_0};
        vecs[5] = '{8'h00, 10'b1_00000000_0};
        vecs[6] = '{8'hFF, 10'b1_11111111_0};
        vecs[7] = '{8'h80, 10'b1_10000000_0};

        rst = 1'b1;
        bus.send = 1'b0;
        bus.data = 8'h00;
        repeat (3) tick();
        check("reset line", int'(bus.rs_232), 1);
        check("reset busy", int'(bus.busy), 0);
        check("reset done", int'(bus.done), 0);
        rst = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 8; i++) begin
            start_frame(vecs[i].data);
            run_frame($sformatf("vec%0d", i), vecs[i].frame, 1'b0, -1);
            repeat (3) tick();
        end

        // Send while busy: the 0xFF request mid-frame must be ignored.
        start_frame(8'h41);
        run_frame("busy send", 10'b1_01000001_0, 1'b0, 100);
        expect_quiet("busy send", int'(2 * C));

        // Continuous send: each frame starts the cycle after the previous done.
        bus.send = 1'b1;
        bus.data = 8'h6E;
        tick();
        for (int f = 0; f < 3; f++) begin
            run_frame($sformatf("cont%0d", f), 10'b1_01101110_0, 1'b1, -1);
        end
        bus.send = 1'b0;
        // The third done edge accepted one more frame; finish it cleanly.
        run_frame("cont tail", 10'b1_01101110_0, 1'b0, -1);
        repeat (2) tick();

        // Reset during data bit 3 of 0x6C (line carries data[3]=1 there).
        start_frame(8'h6C);
        repeat (4 * C + C / 2) tick();
        check("mid bit3 line", int'(bus.rs_232), 1);
        check("mid bit3 busy", int'(bus.busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort line", int'(bus.rs_232), 1);
        check("abort busy", int'(bus.busy), 0);
        check("abort done", int'(bus.done), 0);
        expect_quiet("abort", int'(11 * C));
        start_frame(8'h61);
        run_frame("after abort", 10'b1_01100001_0, 1'b0, -1);
        repeat (2) tick();

        // Reset and send together: reset wins, then the frame follows the first free edge.
        rst = 1'b1;
        bus.send = 1'b1;
        bus.data = 8'h80;
        for (int k = 0; k < 5; k++) begin
            tick();
            check($sformatf("rst+send line %0d", k), int'(bus.rs_232), 1);
            check($sformatf("rst+send busy %0d", k), int'(bus.busy), 0);
        end
        rst = 1'b0;
        tick();
        bus.send = 1'b0;
        run_frame("post reset", 10'b1_10000000_0, 1'b0, -1);
        expect_quiet("post reset", int'(C));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, expected finish before 2000000");
        $fatal(1);
    end

endmodule
